// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and default widths for the fifo burst reader.
package fifo_burst_reader_pkg;
  localparam int BUSW_DEF = 32;
  localparam int LENW_DEF = 8;

  typedef enum logic [1:0] {IDLE, PULL, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/fifo_burst_reader_if.sv
// Fifo pop side plus downstream valid/ready stream of the burst reader.
interface fifo_burst_reader_if
  import fifo_burst_reader_pkg::*;
#(
  parameter int BUSW = BUSW_DEF
);
  logic            empty;
  logic [BUSW-1:0] dataout;
  logic            pull;
  logic            m_valid;
  logic [BUSW-1:0] m_data;
  logic            m_last;
  logic            m_ready;

  modport master (input empty, dataout, m_ready, output pull, m_valid, m_data, m_last);
  modport slave  (output empty, dataout, m_ready, input pull, m_valid, m_data, m_last);
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry valid/ready buffer carrying data plus a last tag; head is entry 0.
// Simultaneous push and pop keep occupancy; the writer must not push into a full buffer without a pop.
module fifo_burst_reader_skid
  import fifo_burst_reader_pkg::*;
#(
  parameter int W = BUSW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_last_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o,
  output logic [1:0]   occ_o
);
  logic [W:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] occ_q, occ_d;
  logic       pop;

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = ent0_q[W-1:0];
  assign out_last_o  = ent0_q[W];
  assign occ_o       = occ_q;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({in_valid_i, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = {in_last_i, in_data_i};
        else               ent1_d = {in_last_i, in_data_i};
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // head leaves while a new word arrives: shift and append
        if (occ_q == 2'd1) begin
          ent0_d = {in_last_i, in_data_i};
        end else begin
          ent0_d = ent1_q;
          ent1_d = {in_last_i, in_data_i};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Drains exactly len words from a fall-through fifo onto a valid/ready stream, tagging the last word.
// Pull-to-m_valid latency is one cycle; abort stops pulling and lets buffered words drain.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int BUSW = BUSW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [LENW-1:0]     len_i,
  input  logic                abort_i,
  fifo_burst_reader_if.master bus,
  output logic                busy_o,
  output logic                done_o,
  output logic [LENW-1:0]     count_o
);
  rd_state_t       state_q, state_d;
  logic [LENW-1:0] remaining_q, remaining_d;
  logic [LENW-1:0] count_q, count_d;
  logic [1:0]      occ;
  logic            skid_valid, skid_last;
  logic [BUSW-1:0] skid_data;
  logic            hs, buf_space, pull;

  assign hs        = skid_valid && bus.m_ready;
  assign buf_space = (occ < 2'd2) || hs;

  fifo_burst_reader_skid #(.W(BUSW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (pull),
    .in_data_i   (bus.dataout),
    .in_last_i   (remaining_q == LENW'(1)),
    .out_ready_i (bus.m_ready),
    .out_valid_o (skid_valid),
    .out_data_o  (skid_data),
    .out_last_o  (skid_last),
    .occ_o       (occ)
  );

  // In DRAIN nothing else is coming, so a lone buffered word closes an aborted burst.
  assign bus.m_valid = skid_valid;
  assign bus.m_data  = skid_data;
  assign bus.m_last  = skid_valid && (skid_last || (state_q == DRAIN && occ == 2'd1));
  assign bus.pull    = pull;
  assign count_o     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = (len_i != '0) ? PULL : DONE;
      PULL:  if (abort_i || (pull && remaining_q == LENW'(1))) state_d = DRAIN;
      DRAIN: if (occ == 2'd0 || (occ == 2'd1 && hs)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    pull   = (state_q == PULL) && !bus.empty && (remaining_q != '0) && !abort_i && buf_space;
  end

  always_comb begin
    remaining_d = remaining_q;
    count_d     = count_q;
    if (state_q == IDLE && start_i) begin
      remaining_d = len_i;
      count_d     = '0;
    end else begin
      if (pull) remaining_d = remaining_q - LENW'(1);
      if (hs)   count_d     = count_q + LENW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based fifo plus a transaction-level model checked every cycle.
module tb_fifo_burst_reader;
  import fifo_burst_reader_pkg::*;
  localparam int BUSW = 32;
  localparam int LENW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic [LENW-1:0] len_i = '0;
  logic abort_i = 1'b0;
  logic busy_o, done_o;
  logic [LENW-1:0] count_o;

  always #5 clk = ~clk;

  fifo_burst_reader_if #(.BUSW(BUSW)) bus ();

  fifo_burst_reader #(.BUSW(BUSW), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
    .bus(bus.master), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  logic [BUSW-1:0] fq[$];
  logic [BUSW-1:0] exp_q[$];
  logic [BUSW-1:0] got_q[$];
  bit              got_last[$];
  int checks = 0;
  int errors = 0;

  // transaction-level model: a burst is len, words pulled, words delivered, abort flag
  bit m_busy = 0, m_donep = 0, m_ab = 0;
  int m_len = 0, m_pulled = 0, m_deliv = 0;

  int rdy_mode = 0;
  int push_pct = 0;
  int cyc_n = 0;
  logic [BUSW-1:0] wseq = 32'h5000_0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.empty = (fq.size() == 0);
    if (fq.size() > 0) bus.dataout = fq[0];
    else               bus.dataout = '0;
  endtask

  task automatic push_words(input logic [BUSW-1:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + BUSW'(i));
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
    case (rdy_mode)
      0: bus.m_ready = 1'b1;
      1: bus.m_ready = (cyc_n % 3 == 0);
      2: bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
    if (push_pct > 0 && $urandom_range(0, 99) < push_pct) begin
      fq.push_back(wseq);
      wseq++;
    end
    refresh();
  endtask

  task automatic do_start(input int n);
    start_i = 1'b1;
    len_i = LENW'(n);
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    for (int i = 0; i < budget && busy_o; i++) step();
    chk({nm, "_finished"}, busy_o, 0);
  endtask

  always @(negedge clk) begin : cmp
    int outst;
    bit e_valid, e_pull, e_last, pulling, hs, ab_old, busy_old;
    logic [BUSW-1:0] w;
    if (!rst_n) begin
      m_busy = 0; m_donep = 0; m_ab = 0; m_len = 0; m_pulled = 0; m_deliv = 0;
      exp_q.delete();
    end
    outst   = m_pulled - m_deliv;
    e_valid = outst > 0;
    pulling = m_busy && !m_donep && (m_pulled < m_len) && !m_ab;
    e_pull  = pulling && !abort_i && (fq.size() > 0) && (outst < 2 || (e_valid && bus.m_ready));
    e_last  = (outst == 1) && (m_pulled == m_len || m_ab);
    chk("busy", busy_o, m_busy);
    chk("done", done_o, m_donep);
    chk("pull", bus.pull, e_pull);
    chk("m_valid", bus.m_valid, e_valid);
    chk("count", count_o, m_deliv);
    if (e_valid) begin
      chk("m_data", bus.m_data, exp_q[0]);
      chk("m_last", bus.m_last, e_last);
    end else begin
      chk("m_last_novalid", bus.m_last, 0);
    end
    if (rst_n) begin
      ab_old   = m_ab;
      busy_old = m_busy;
      hs = e_valid && bus.m_ready;
      if (hs) begin
        got_q.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
        w = exp_q.pop_front();
        m_deliv++;
      end
      if (bus.pull === 1'b1 && fq.size() > 0) begin
        w = fq.pop_front();
        if (e_pull) exp_q.push_back(w);
      end
      if (e_pull) m_pulled++;
      if (pulling && abort_i) m_ab = 1;
      if (m_donep) begin
        m_busy = 0;
        m_donep = 0;
      end else if (m_busy && (m_pulled == m_len || ab_old) && (m_pulled == m_deliv)) begin
        m_donep = 1;
      end
      if (start_i && !busy_old) begin
        m_busy = 1; m_len = int'(len_i); m_pulled = 0; m_deliv = 0; m_ab = 0;
        m_donep = (len_i == '0);
        exp_q.delete();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_ready = 1'b0;
    refresh();
    // reset state
    step(); step();
    chk("rst_busy", busy_o, 0);
    chk("rst_mvalid", bus.m_valid, 0);
    chk("rst_pull", bus.pull, 0);
    rst_n = 1'b1;
    step();
    chk("rst_count", count_o, 0);

    // basic burst of 4 out of 6
    rdy_mode = 0;
    got_q.delete(); got_last.delete();
    push_words(32'hA000_0000, 6);
    do_start(4);
    wait_idle("t1", 200);
    chk("t1_nwords", got_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_word", got_q[i], 32'hA000_0000 + i);
    chk("t1_last3", got_last[3], 1);
    chk("t1_last2", got_last[2], 0);
    chk("t1_count", count_o, 4);
    chk("t1_left", fq.size(), 2);
    fq.delete(); refresh();

    // backpressure 1,0,0 pattern
    rdy_mode = 1;
    got_q.delete(); got_last.delete();
    push_words(32'hB000_0000, 5);
    do_start(5);
    wait_idle("t2", 200);
    chk("t2_nwords", got_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_word", got_q[i], 32'hB000_0000 + i);
    chk("t2_count", count_o, 5);

    // empty fifo stall mid-burst
    rdy_mode = 0;
    got_q.delete(); got_last.delete();
    push_words(32'hC000_0000, 2);
    do_start(4);
    for (int i = 0; i < 6; i++) step();
    chk("t3_stall_pull", bus.pull, 0);
    chk("t3_stall_busy", busy_o, 1);
    chk("t3_stall_words", got_q.size(), 2);
    push_words(32'hC000_0002, 2);
    wait_idle("t3", 200);
    chk("t3_nwords", got_q.size(), 4);
    chk("t3_word3", got_q[3], 32'hC000_0003);
    chk("t3_last3", got_last[3], 1);

    // zero length burst
    push_words(32'hD000_0000, 3);
    do_start(0);
    chk("t4_done", done_o, 1);
    chk("t4_pull", bus.pull, 0);
    step();
    chk("t4_idle", busy_o, 0);
    chk("t4_count", count_o, 0);
    chk("t4_fifo", fq.size(), 3);
    fq.delete(); refresh();

    // abort with stalled consumer
    rdy_mode = 3;
    got_q.delete(); got_last.delete();
    push_words(32'hE000_0000, 10);
    do_start(8);
    for (int i = 0; i < 4; i++) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rdy_mode = 0;
    wait_idle("t5", 200);
    chk("t5_nwords", got_q.size(), 2);
    chk("t5_last0", got_last[0], 0);
    chk("t5_last1", got_last[1], 1);
    chk("t5_count", count_o, 2);
    chk("t5_fifo", fq.size(), 8);
    fq.delete(); refresh();

    // asynchronous reset with a full buffer
    rdy_mode = 3;
    push_words(32'hF000_0000, 10);
    do_start(6);
    for (int i = 0; i < 3; i++) step();
    chk("t6_pre_valid", bus.m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", bus.m_valid, 0);
    chk("t6_arst_busy", busy_o, 0);
    chk("t6_arst_pull", bus.pull, 0);
    chk("t6_arst_last", bus.m_last, 0);
    chk("t6_arst_count", count_o, 0);
    step();
    rst_n = 1'b1;
    chk("t6_fifo", fq.size(), 8);
    fq.delete(); refresh();
    rdy_mode = 0;
    got_q.delete(); got_last.delete();
    push_words(32'h1200_0000, 3);
    do_start(3);
    wait_idle("t6", 200);
    chk("t6_nwords", got_q.size(), 3);
    chk("t6_word0", got_q[0], 32'h1200_0000);
    chk("t6_last2", got_last[2], 1);

    // randomized bursts with random ready, pushes, aborts and ignored starts
    rdy_mode = 2;
    push_pct = 40;
    for (int b = 0; b < 25; b++) begin
      int n;
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        fq.push_back(wseq);
        wseq++;
      end
      refresh();
      do_start($urandom_range(1, 12));
      for (int i = 0; i < 400 && busy_o; i++) begin
        abort_i = ($urandom_range(0, 24) == 0);
        start_i = ($urandom_range(0, 29) == 0);
        len_i   = LENW'($urandom_range(0, 12));
        step();
      end
      abort_i = 1'b0;
      start_i = 1'b0;
      chk("rnd_finished", busy_o, 0);
      step();
    end
    push_pct = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
